// File: rtl/counter_fifo_core.sv
// ----------------------------------------------------------------------------
// counter_fifo_core
//
// A 32-bit up/down counter with a wrap interrupt, alongside an independent
// first-word-fall-through byte FIFO.
//
// Ports
//   clk              sole clock, all state updates on the rising edge
//   reset            asynchronous, active-high reset of all state
//   count_we         load count register from count_in (beats counting)
//   config_we        load en/dir/ire from en_in/dir_in/ire_in
//   fifo_we          push fifo_data_in (dropped when full)
//   fifo_re          pop head entry (ignored when empty)
//   count_in         count write data
//   en_in            config write data: count enable
//   dir_in           config write data: 0 = up, 1 = down
//   ire_in           config write data: wrap interrupt enable
//   fifo_data_in     FIFO write data
//   count_out        count register
//   en_out           count enable
//   dir_out          count direction
//   ire_out          wrap interrupt enable
//   lt_1k_out        count_out < 1000 (unsigned)
//   fifo_empty       FIFO holds no entries
//   fifo_full        FIFO holds FIFO_DEPTH entries
//   fifo_word_count  number of stored entries
//   fifo_data_out    head entry, 0x00 while empty
//   irq              one-cycle pulse following a counting wrap
// ----------------------------------------------------------------------------
module counter_fifo_core #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        config_we,
    input  logic        fifo_we,
    input  logic        fifo_re,
    input  logic [31:0] count_in,
    input  logic        en_in,
    input  logic        dir_in,
    input  logic        ire_in,
    input  logic [7:0]  fifo_data_in,
    output logic [31:0] count_out,
    output logic        en_out,
    output logic        dir_out,
    output logic        ire_out,
    output logic        lt_1k_out,
    output logic        fifo_empty,
    output logic        fifo_full,
    output logic [7:0]  fifo_word_count,
    output logic [7:0]  fifo_data_out,
    output logic        irq
);

    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam logic [7:0]  DEPTH_CNT = 8'(FIFO_DEPTH);

    // ------------------------------------------------------------------------
    // Counter
    // ------------------------------------------------------------------------
    logic [31:0] r_count;
    logic        r_en;
    logic        r_dir;
    logic        r_ire;
    logic        r_irq;

    logic [31:0] w_count_next;
    logic        w_wrap;

    // A load always wins over a step, and a load never counts as a wrap.
    always_comb begin
        w_count_next = r_count;
        w_wrap       = 1'b0;
        if (count_we) begin
            w_count_next = count_in;
        end else if (r_en) begin
            if (r_dir) begin
                w_count_next = r_count - 32'd1;
                w_wrap       = (r_count == 32'h0000_0000);
            end else begin
                w_count_next = r_count + 32'd1;
                w_wrap       = (r_count == 32'hFFFF_FFFF);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 32'h0;
            r_en    <= 1'b0;
            r_dir   <= 1'b0;
            r_ire   <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_irq   <= w_wrap & r_ire;
            if (config_we) begin
                r_en  <= en_in;
                r_dir <= dir_in;
                r_ire <= ire_in;
            end
        end
    end

    assign count_out = r_count;
    assign en_out    = r_en;
    assign dir_out   = r_dir;
    assign ire_out   = r_ire;
    assign irq       = r_irq;
    assign lt_1k_out = (r_count < 32'd1000);

    // ------------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------------
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [7:0]    r_wcount;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_wcount == 8'd0);
    assign w_full  = (r_wcount == DEPTH_CNT);
    assign w_push  = fifo_we & ~w_full;
    assign w_pop   = fifo_re & ~w_empty;

    // Storage is not reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= fifo_data_in;
        end
    end

    // Pointers are exactly log2(depth) bits wide, so they wrap on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_wcount <= 8'd0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_wcount <= r_wcount + 8'd1;
            end else if (w_pop && !w_push) begin
                r_wcount <= r_wcount - 8'd1;
            end
        end
    end

    assign fifo_empty      = w_empty;
    assign fifo_full       = w_full;
    assign fifo_word_count = r_wcount;
    assign fifo_data_out   = w_empty ? 8'h00 : r_mem[r_rptr];

endmodule

// File: tb/tb_counter_fifo_core.sv
module tb_counter_fifo_core;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        count_we = 1'b0;
    logic        config_we = 1'b0;
    logic        fifo_we = 1'b0;
    logic        fifo_re = 1'b0;
    logic [31:0] count_in = 32'h0;
    logic        en_in = 1'b0;
    logic        dir_in = 1'b0;
    logic        ire_in = 1'b0;
    logic [7:0]  fifo_data_in = 8'h0;
    logic [31:0] count_out;
    logic        en_out;
    logic        dir_out;
    logic        ire_out;
    logic        lt_1k_out;
    logic        fifo_empty;
    logic        fifo_full;
    logic [7:0]  fifo_word_count;
    logic [7:0]  fifo_data_out;
    logic        irq;

    always #5 clk = ~clk;

    counter_fifo_core #(
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .count_we       (count_we),
        .config_we      (config_we),
        .fifo_we        (fifo_we),
        .fifo_re        (fifo_re),
        .count_in       (count_in),
        .en_in          (en_in),
        .dir_in         (dir_in),
        .ire_in         (ire_in),
        .fifo_data_in   (fifo_data_in),
        .count_out      (count_out),
        .en_out         (en_out),
        .dir_out        (dir_out),
        .ire_out        (ire_out),
        .lt_1k_out      (lt_1k_out),
        .fifo_empty     (fifo_empty),
        .fifo_full      (fifo_full),
        .fifo_word_count(fifo_word_count),
        .fifo_data_out  (fifo_data_out),
        .irq            (irq)
    );

    // Reference model
    logic [31:0] m_count;
    logic        m_en;
    logic        m_dir;
    logic        m_ire;
    logic        m_irq;
    logic [7:0]  m_q[$];

    int    n_pass = 0;
    int    n_checks = 0;
    string phase = "init";

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    endtask

    task automatic check_all();
        logic [7:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 8'h00;
        check("count_out", count_out, m_count);
        check("en_out", {31'b0, en_out}, {31'b0, m_en});
        check("dir_out", {31'b0, dir_out}, {31'b0, m_dir});
        check("ire_out", {31'b0, ire_out}, {31'b0, m_ire});
        check("lt_1k_out", {31'b0, lt_1k_out}, {31'b0, (m_count < 32'd1000)});
        check("irq", {31'b0, irq}, {31'b0, m_irq});
        check("fifo_empty", {31'b0, fifo_empty}, {31'b0, (m_q.size() == 0)});
        check("fifo_full", {31'b0, fifo_full}, {31'b0, (m_q.size() == DEPTH)});
        check("fifo_word_count", {24'b0, fifo_word_count}, 32'(m_q.size()));
        check("fifo_data_out", {24'b0, fifo_data_out}, {24'b0, head});
    endtask

    task automatic model_reset();
        m_count = 32'h0;
        m_en    = 1'b0;
        m_dir   = 1'b0;
        m_ire   = 1'b0;
        m_irq   = 1'b0;
        m_q.delete();
    endtask

    // Predict the effect of the current inputs, clock once, then compare.
    task automatic tick();
        logic [32:0] ext;
        logic [31:0] n_count;
        logic        n_irq;
        logic        do_push;
        logic        do_pop;
        n_count = m_count;
        n_irq   = 1'b0;
        if (count_we) begin
            n_count = count_in;
        end else if (m_en) begin
            if (m_dir) ext = {1'b0, m_count} - 33'd1;
            else       ext = {1'b0, m_count} + 33'd1;
            n_count = ext[31:0];
            n_irq   = ext[32] & m_ire;   // carry or borrow out of 32 bits
        end
        do_push = fifo_we && (m_q.size() < DEPTH);
        do_pop  = fifo_re && (m_q.size() > 0);
        @(posedge clk);
        #1;
        m_count = n_count;
        m_irq   = n_irq;
        if (config_we) begin
            m_en  = en_in;
            m_dir = dir_in;
            m_ire = ire_in;
        end
        if (do_pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back(fifo_data_in);
        check_all();
    endtask

    task automatic idle();
        count_we  = 1'b0;
        config_we = 1'b0;
        fifo_we   = 1'b0;
        fifo_re   = 1'b0;
    endtask

    task automatic load(input logic [31:0] v, input logic en, input logic dir, input logic ire);
        count_we  = 1'b1;
        count_in  = v;
        config_we = 1'b1;
        en_in     = en;
        dir_in    = dir;
        ire_in    = ire;
        tick();
        count_we  = 1'b0;
        config_we = 1'b0;
    endtask

    initial begin
        // Reset state
        phase = "reset";
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        reset = 1'b0;

        // Count across 1000
        phase = "lt1k";
        load(32'd998, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();

        // Up wrap with and without interrupt enable
        phase = "wrap_up_ire";
        load(32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1);
        repeat (4) tick();
        phase = "wrap_up_noire";
        load(32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        repeat (4) tick();

        // Down wrap, then a load overriding the step
        phase = "wrap_down";
        load(32'd1, 1'b1, 1'b1, 1'b1);
        repeat (4) tick();
        phase = "load_override";
        count_we = 1'b1;
        count_in = 32'h0000_1234;
        tick();
        count_we = 1'b0;
        tick();
        // Loading a wrap result must not raise irq
        phase = "load_no_irq";
        load(32'h0, 1'b1, 1'b0, 1'b1);
        load(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        tick();

        // FIFO fill, overflow, drain, underflow
        phase = "fifo_fill";
        for (int i = 1; i <= 17; i++) begin
            fifo_we      = 1'b1;
            fifo_data_in = 8'(i);
            tick();
        end
        fifo_we = 1'b0;
        phase = "fifo_drain";
        fifo_re = 1'b1;
        repeat (17) tick();
        fifo_re = 1'b0;

        // Simultaneous push/pop when full and half-full across pointer wrap
        phase = "fifo_both_full";
        for (int i = 0; i < DEPTH; i++) begin
            fifo_we      = 1'b1;
            fifo_data_in = 8'h40 + 8'(i);
            tick();
        end
        fifo_re      = 1'b1;
        fifo_data_in = 8'hA0;
        tick();
        fifo_we = 1'b0;
        repeat (7) tick();
        phase = "fifo_both_half";
        fifo_we = 1'b1;
        for (int i = 0; i < 20; i++) begin
            fifo_data_in = 8'hB0 + 8'(i);
            tick();
        end
        fifo_we = 1'b0;
        repeat (10) tick();
        fifo_re = 1'b0;

        // Randomized traffic
        phase = "random";
        for (int i = 0; i < 400; i++) begin
            count_we  = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       count_in = $urandom();
                1:       count_in = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
                2:       count_in = 32'($urandom_range(0, 2));
                default: count_in = 32'd997 + 32'($urandom_range(0, 5));
            endcase
            config_we    = ($urandom_range(0, 7) == 0);
            en_in        = ($urandom_range(0, 3) != 0);
            dir_in       = 1'($urandom_range(0, 1));
            ire_in       = 1'($urandom_range(0, 1));
            fifo_we      = 1'($urandom_range(0, 1));
            fifo_re      = 1'($urandom_range(0, 1));
            fifo_data_in = 8'($urandom());
            tick();
        end
        idle();

        // Asynchronous reset mid-count with 5 words stored
        phase = "async_reset";
        load(32'd500, 1'b1, 1'b0, 1'b1);
        while (m_q.size() > 0) begin
            fifo_re = 1'b1;
            tick();
        end
        fifo_re = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fifo_we      = 1'b1;
            fifo_data_in = 8'hC0 + 8'(i);
            tick();
        end
        fifo_we = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();

        // First edge after release honours strobes
        phase = "post_reset";
        count_we     = 1'b1;
        count_in     = 32'd5;
        config_we    = 1'b1;
        en_in        = 1'b1;
        dir_in       = 1'b0;
        ire_in       = 1'b0;
        fifo_we      = 1'b1;
        fifo_data_in = 8'h5A;
        #2;
        reset = 1'b0;
        tick();
        idle();
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
